// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the WISC datapath and the pipeline sequencing controller.
// The datapath (master) drives hazard-detection inputs; the controller (slave)
// returns register write enables, bubble requests, the ret redirect select and
// status.
//   id_rs/id_rt, id_uses_rs/id_uses_rt, id_ret : ID-stage operand and ret info
//   ex_mem_read, ex_rd, ex_branch_taken        : EX-stage load/branch info
//   mem_req, mem_ready                         : MEM-stage data access handshake
//   wb_ret                                     : ret flag at MEM/WB output
//   *_en, *_flush, pc_sel_ret                  : pipeline register controls
//   ret_busy, mem_timeout, stall_cycles        : status
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       id_rs;
    logic [3:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_ret;
    logic             ex_mem_read;
    logic [3:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             wb_ret;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pc_sel_ret;
    logic             ret_busy;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_ret,
        output ex_mem_read, ex_rd, ex_branch_taken,
        output mem_req, mem_ready, wb_ret,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, pc_sel_ret,
        input  ret_busy, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_ret,
        input  ex_mem_read, ex_rd, ex_branch_taken,
        input  mem_req, mem_ready, wb_ret,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, pc_sel_ret,
        output ret_busy, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 16-bit WISC core. Generates the PC and
// pipeline-register write enables and bubble requests, resolving load-use
// hazards, taken-branch squashes, data-memory waits (freeze) and the ret
// drain/redirect sequence. Holds only control state and counters.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pipe_hazard_ctrl_if slave port (hazard inputs, control outputs)
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

    localparam logic [0:0] StRun      = 1'b0;
    localparam logic [0:0] StRetDrain = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic freeze;
    logic load_use;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, pc_sel_ret;

    assign freeze   = bus.mem_req & ~bus.mem_ready;
    assign load_use = bus.ex_mem_read & (bus.ex_rd != 4'd0) &
                      ((bus.id_uses_rs & (bus.id_rs == bus.ex_rd)) |
                       (bus.id_uses_rt & (bus.id_rt == bus.ex_rd)));

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pc_sel_ret = 1'b0;

        if (rst) begin
            // Outputs read as all-off while reset is held.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (state_q == StRun) begin
            if (bus.ex_branch_taken) begin
                // Squash wins over ret entry and load-use: both are wrong-path.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (bus.id_ret) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                state_d    = StRetDrain;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end else begin
            // Only bubbles follow the ret, so branch/load-use cannot occur here.
            ifid_flush = 1'b1;
            if (bus.wb_ret) begin
                pc_sel_ret = 1'b1;
                state_d    = StRun;
            end else begin
                pc_en = 1'b0;
            end
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_q == WaitMax) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.idex_en      = idex_en;
    assign bus.exmem_en     = exmem_en;
    assign bus.memwb_en     = memwb_en;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.pc_sel_ret   = pc_sel_ret;
    assign bus.ret_busy     = (state_q == StRetDrain);
    assign bus.mem_timeout  = timeout_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table of single-cycle RUN-state vectors plus
// hand-written ret, freeze, timeout and reset sequences.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(3),
        .CNT_W      (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bit order:
    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    //  pc_sel_ret, ret_busy, mem_timeout}
    localparam logic [9:0] DEF   = 10'b11111_00_0_0_0;
    localparam logic [9:0] LU    = 10'b00111_01_0_0_0;
    localparam logic [9:0] BR    = 10'b11111_11_0_0_0;
    localparam logic [9:0] FRZ   = 10'b00000_00_0_0_0;
    localparam logic [9:0] RETIN = 10'b01111_10_0_0_0;
    localparam logic [9:0] DRN   = 10'b01111_10_0_1_0;
    localparam logic [9:0] DRNF  = 10'b00000_00_0_1_0;
    localparam logic [9:0] REDIR = 10'b11111_10_1_1_0;

    typedef struct {
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urs;
        logic       urt;
        logic       ret;
        logic       mrd;
        logic [3:0] rd;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic       wret;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   total = 0;
    int   bad   = 0;
    int   stall_exp;

    function automatic logic [9:0] outs();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.pc_sel_ret, bus.ret_busy,
                bus.mem_timeout};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        bus.id_rs           = v.rs;
        bus.id_rt           = v.rt;
        bus.id_uses_rs      = v.urs;
        bus.id_uses_rt      = v.urt;
        bus.id_ret          = v.ret;
        bus.ex_mem_read     = v.mrd;
        bus.ex_rd           = v.rd;
        bus.ex_branch_taken = v.br;
        bus.mem_req         = v.mreq;
        bus.mem_ready       = v.mrdy;
        bus.wb_ret          = v.wret;
    endtask

    task automatic idle();
        vec_t v;
        v = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
        set_in(v);
    endtask

    // Sample at the falling edge, then advance one clock.
    task automatic cyc(input string name, input logic [9:0] exp);
        @(negedge clk);
        check(name, {22'd0, outs()}, {22'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
        vecs[1]  = '{4'd5, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[2]  = '{4'd2, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[3]  = '{4'd5, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
        vecs[4]  = '{4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
        vecs[5]  = '{4'd9, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
        vecs[6]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, BR};
        vecs[7]  = '{4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, BR};
        vecs[8]  = '{4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, LU};
        vecs[9]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, DEF};
        vecs[10] = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF};
        vecs[11] = '{4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, FRZ};

        // Reset values while rst is held.
        idle();
        rst = 1'b1;
        #2;
        check("reset_outs", {22'd0, outs()}, 32'd0);
        check("reset_stall", {16'd0, bus.stall_cycles}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table of single-cycle vectors; none of them leaves RUN.
        stall_exp = 0;
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i]);
            cyc($sformatf("vec%0d", i), vecs[i].exp);
            if (!vecs[i].exp[9]) stall_exp++;
        end
        idle();
        check("table_stall", {16'd0, bus.stall_cycles}, stall_exp);

        // Load-use bubble lasts one cycle.
        do_reset();
        set_in(vecs[1]);
        cyc("lu_hit", LU);
        idle();
        cyc("lu_after", DEF);
        check("lu_stall", {16'd0, bus.stall_cycles}, 32'd1);
        set_in(vecs[4]);
        cyc("lu_rd0", DEF);
        check("lu_rd0_stall", {16'd0, bus.stall_cycles}, 32'd1);

        // Ret sequence: t..t+3, back in RUN at t+4.
        do_reset();
        bus.id_ret = 1'b1;
        cyc("ret_t0", RETIN);
        bus.id_ret = 1'b0;
        cyc("ret_t1", DRN);
        cyc("ret_t2", DRN);
        bus.wb_ret = 1'b1;
        cyc("ret_t3", REDIR);
        bus.wb_ret = 1'b0;
        cyc("ret_t4", DEF);
        check("ret_stall", {16'd0, bus.stall_cycles}, 32'd3);

        // Ret with a 2-cycle freeze at t+2: redirect moves to t+5.
        do_reset();
        bus.id_ret = 1'b1;
        cyc("rf_t0", RETIN);
        bus.id_ret = 1'b0;
        cyc("rf_t1", DRN);
        bus.mem_req = 1'b1;
        cyc("rf_t2", DRNF);
        cyc("rf_t3", DRNF);
        bus.mem_req = 1'b0;
        cyc("rf_t4", DRN);
        bus.wb_ret = 1'b1;
        cyc("rf_t5", REDIR);
        bus.wb_ret = 1'b0;
        cyc("rf_t6", DEF);
        check("rf_stall", {16'd0, bus.stall_cycles}, 32'd5);

        // Freeze for 5 cycles with MEM_TIMEOUT=3: timeout after 4th freeze edge.
        do_reset();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc($sformatf("frz%0d", i), FRZ);
        cyc("frz4_timeout", FRZ | 10'd1);
        bus.mem_ready = 1'b1;
        cyc("frz_ready", DEF | 10'd1);
        idle();
        cyc("timeout_sticky", DEF | 10'd1);
        check("frz_stall", {16'd0, bus.stall_cycles}, 32'd5);

        // Async reset mid-drain; mem_timeout is still set from above.
        bus.id_ret = 1'b1;
        cyc("rr_t0", RETIN | 10'd1);
        bus.id_ret = 1'b0;
        cyc("rr_t1", DRN | 10'd1);
        rst = 1'b1;
        #1;
        check("rr_outs", {22'd0, outs()}, 32'd0);
        check("rr_stall", {16'd0, bus.stall_cycles}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rr_run", DEF);
        check("rr_stall_after", {16'd0, bus.stall_cycles}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 16-bit WISC core. It drives the write enables and bubble (flush) requests of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch squashes, multi-cycle data-memory waits and the `ret` drain/redirect sequence. It sits beside the datapath and holds no datapath values, only control state and counters.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: freeze cycles after which `mem_timeout` sets.
- CNT_W, default 16: width of the `stall_cycles` counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  4 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- id_ret  in  1  ID holds a `ret`
- ex_mem_read  in  1  EX holds a load
- ex_rd  in  4  EX destination register
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  MEM-stage data access in progress
- mem_ready  in  1  data memory completes this cycle
- wb_ret  in  1  `ret` flag at the MEM/WB register output
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register write enables
- ifid_flush, idex_flush  out  1 each  load a bubble (control bits cleared) instead of data
- pc_sel_ret  out  1  PC loads the MEM/WB read data (return address)
- ret_busy  out  1  controller is in RET_DRAIN
- mem_timeout  out  1  sticky memory-timeout error
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
- State machine has two states: RUN and RET_DRAIN. There is also a freeze overlay with a wait counter `wait_cnt` of width ceil(log2(MEM_TIMEOUT+1)).
- Default in either state: all enables 1, flushes 0, pc_sel_ret 0.
- A flush is asserted only together with that register's enable = 1.
- Priority, evaluated each cycle from the highest:
  1. **Freeze** when mem_req & !mem_ready. All five enables are 0, flushes are 0 and pc_sel_ret is 0. The state is held and `wait_cnt` increments, saturating.
  2. **Branch squash**, RUN only: ex_branch_taken. Sets ifid_flush=1 and idex_flush=1. The state stays RUN, and any id_ret or load-use condition is discarded.
  3. **Ret entry**, RUN only: id_ret. Sets pc_en=0 and ifid_flush=1. The `ret` advances into ID/EX. Next state is RET_DRAIN.
  4. **Load-use**, RUN only: ex_mem_read & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)). Sets pc_en=0, ifid_en=0 and idex_flush=1. The bubble lasts one cycle per occurrence.
- **RET_DRAIN behaviour:**
  - While wb_ret=0: pc_en=0, ifid_flush=1, other enables 1.
  - While wb_ret=1: pc_en=1, pc_sel_ret=1, ifid_flush=1, and next state is RUN.
  - ex_branch_taken and load-use are ignored here, because only bubbles trail the `ret`.
- **wait_cnt:** cleared in any non-freeze cycle. When a freeze cycle sees wait_cnt == MEM_TIMEOUT, mem_timeout sets to 1 and holds until rst.
- **stall_cycles:** increments at each edge where pc_en was 0, including freeze cycles, and saturates at all-ones.
- ret_busy = (state == RET_DRAIN).
- **Reset values** (held while rst=1):
  - state RUN, wait_cnt 0, mem_timeout 0, stall_cycles 0.
  - All enables 0, flushes 0, pc_sel_ret 0, ret_busy 0.

## Timing
- All control outputs are combinational from the current state and inputs, so a stall or flush takes effect at the same edge.
- Registered elements are state, wait_cnt, mem_timeout and stall_cycles.
- **Ret latency:** id_ret in cycle t; wb_ret is high in t+3 with no freeze, and that same cycle redirects. Fetch at the return address starts in t+4, so pc_en=0 for cycles t..t+2.
- Each freeze cycle delays this sequence by one cycle. The state is preserved across a freeze.
- A freeze that coincides with wb_ret=1 holds the redirect until mem_ready.
- Asynchronous rst in RET_DRAIN returns immediately to RUN and all outputs go to their reset values. No redirect is issued.
- mem_ready=1 with mem_req=1 is not a freeze, and normal priority resolves in that cycle.

## Test plan
- **Load-use:** ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 for one cycle.
  - Required: pc_en=0, ifid_en=0, idex_flush=1 in that cycle; all defaults the next cycle; stall_cycles=1.
  - Repeat with ex_rd=0: no stall.
- **Ret sequence:** id_ret pulse at t, wb_ret=1 at t+3.
  - Required: ret_busy=1 in t+1..t+3; pc_en=0 in t..t+2; pc_sel_ret=1 and pc_en=1 at t+3; RUN at t+4; stall_cycles=3.
- **Branch priority:** ex_branch_taken=1, id_ret=1 and a load-use match in the same cycle.
  - Required: ifid_flush=idex_flush=1, pc_en=1, state remains RUN.
- **Freeze and timeout:** MEM_TIMEOUT=3, mem_req=1, mem_ready=0 for 5 cycles.
  - Required: all enables 0 for 5 cycles; mem_timeout rises after the 4th freeze edge and stays 1 after mem_ready.
- **Freeze during drain:** the ret sequence with a 2-cycle freeze at t+2.
  - Required: redirect at t+5, ret_busy=1 through t+5.
- **Reset mid-drain:** rst asserted at t+2 of a ret sequence.
  - Required: outputs go immediately to reset values; after release the controller is in RUN with stall_cycles=0 and mem_timeout=0.
